// File: rtl/psec_spi_regfile.sv
`default_nettype none
// ============================================================================
// Module   : psec_spi_regfile
// Purpose  : SPI-slave register file. A frame (cs low) carries a command bit
//            (1=write, 0=read), a start address and any number of data words,
//            MSB first. The address auto-increments per word, wrapping at
//            NUM_REGS-1. One address is a write-only instruction strobe, one
//            a read-only status word; illegal writes set a sticky error flag
//            that a status read clears.
// Ports    : spi_clk    - sole clock, rising edge
//            rstn       - asynchronous active-low reset
//            cs         - frame enable, active-low
//            pico       - serial data in
//            status_in  - live status bits returned on status reads
//            poci_spi   - serial data out (registered)
//            reg_bus    - flat image of all registers, slot k = register k
//            inst_pulse - one-cycle instruction word strobe
//            err_flag   - sticky error indicator
// Revision : 1.0 - initial release
// ============================================================================
module psec_spi_regfile #(
  parameter int                          ADDR_W      = 7,
  parameter int                          DATA_W      = 8,
  parameter int                          NUM_REGS    = 16,
  parameter int                          INST_ADDR   = 3,
  parameter int                          STATUS_ADDR = 11,
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL   = '0
) (
  input  logic                         spi_clk,
  input  logic                         rstn,
  input  logic                         cs,
  input  logic                         pico,
  input  logic [DATA_W-1:0]            status_in,
  output logic                         poci_spi,
  output logic [NUM_REGS*DATA_W-1:0]   reg_bus,
  output logic [DATA_W-1:0]            inst_pulse,
  output logic                         err_flag
);

  localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  c_addr_last = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  c_data_last = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] c_inst_addr = ADDR_W'(INST_ADDR);
  localparam logic [ADDR_W-1:0] c_stat_addr = ADDR_W'(STATUS_ADDR);
  localparam logic [ADDR_W-1:0] c_last_reg  = ADDR_W'(NUM_REGS - 1);
  // One bit wider so NUM_REGS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   c_num_regs  = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_ADDR = 2'd2,
    S_DATA = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_cs_prev;
  logic                r_cmd;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_in_sr;
  logic [DATA_W-1:0]   r_out_sr;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic                w_addr_done;
  logic                w_word_done;
  logic [ADDR_W-1:0]   w_addr_full;
  logic [ADDR_W-1:0]   w_addr_inc;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [DATA_W-1:0]   w_rd_word;
  logic [DATA_W-1:0]   w_word;
  logic                w_commit;
  logic                w_wr_err;
  logic                w_wr_inst;
  logic                w_wr_reg;
  logic                w_stat_clr;
  logic                w_unused;

  assign w_unused    = status_in[0];   // slot 0 of status carries err_flag

  assign w_addr_done = (r_state == S_ADDR) && (r_bit_cnt == c_addr_last);
  assign w_word_done = (r_state == S_DATA) && (r_bit_cnt == c_data_last);
  assign w_addr_full = {r_addr[ADDR_W-2:0], pico};
  assign w_addr_inc  = (r_addr == c_last_reg) ? '0 : r_addr + 1'b1;
  assign w_word      = {r_in_sr[DATA_W-2:0], pico};

  // Word to preload for reads: first word at the just-completed address,
  // later words at the address following the word being finished.
  assign w_rd_addr   = w_addr_done ? w_addr_full : w_addr_inc;

  always_comb begin
    w_rd_word = '0;
    if (w_rd_addr == c_stat_addr) begin
      w_rd_word = {status_in[DATA_W-1:1], err_flag};
    end else if (w_rd_addr != c_inst_addr && {1'b0, w_rd_addr} < c_num_regs) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_rd_addr == ADDR_W'(k)) w_rd_word = r_regs[k];
      end
    end
  end

  // cs high overrides everything: a half-finished word never commits.
  assign w_commit   = w_word_done && r_cmd && !cs;
  assign w_wr_inst  = w_commit && (r_addr == c_inst_addr);
  assign w_wr_err   = w_commit && !w_wr_inst &&
                      ((r_addr == c_stat_addr) || ({1'b0, r_addr} >= c_num_regs));
  assign w_wr_reg   = w_commit && !w_wr_inst && !w_wr_err;
  assign w_stat_clr = w_word_done && !r_cmd && !cs && (r_addr == c_stat_addr);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge spi_clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (cs) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        // Only a real cs falling edge starts a frame; after reset release
        // with cs already low, r_cs_prev is 0 and the block waits.
        S_IDLE:  if (r_cs_prev) w_state_nxt = S_CMD;
        S_CMD:   w_state_nxt = S_ADDR;
        S_ADDR:  if (w_addr_done) w_state_nxt = S_DATA;
        S_DATA:  w_state_nxt = S_DATA;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge spi_clk or negedge rstn) begin
    if (!rstn) begin
      r_cs_prev  <= 1'b0;
      r_cmd      <= 1'b0;
      r_bit_cnt  <= '0;
      r_addr     <= '0;
      r_in_sr    <= '0;
      r_out_sr   <= '0;
      inst_pulse <= '0;
      err_flag   <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VAL[k*DATA_W +: DATA_W];
    end else begin
      r_cs_prev  <= cs;
      inst_pulse <= w_wr_inst ? w_word : '0;
      err_flag   <= w_wr_err | (err_flag & ~w_stat_clr);
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_wr_reg && r_addr == ADDR_W'(k)) r_regs[k] <= w_word;
      end

      if (cs) begin
        r_cmd     <= 1'b0;
        r_bit_cnt <= '0;
        r_addr    <= '0;
        r_in_sr   <= '0;
        r_out_sr  <= '0;
      end else begin
        case (r_state)
          S_CMD: begin
            r_cmd     <= pico;
            r_bit_cnt <= '0;
          end
          S_ADDR: begin
            r_addr <= w_addr_full;
            if (w_addr_done) begin
              r_bit_cnt <= '0;
              r_out_sr  <= r_cmd ? '0 : w_rd_word;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          S_DATA: begin
            r_in_sr <= w_word;
            if (w_word_done) begin
              r_bit_cnt <= '0;
              r_addr    <= w_addr_inc;
              r_out_sr  <= r_cmd ? '0 : w_rd_word;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_out_sr  <= {r_out_sr[DATA_W-2:0], 1'b0};
            end
          end
          default: r_bit_cnt <= '0;
        endcase
      end
    end
  end

  assign poci_spi = r_out_sr[DATA_W-1];

  generate
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_bus
      assign reg_bus[k*DATA_W +: DATA_W] = r_regs[k];
    end
  endgenerate

endmodule
`default_nettype wire
